// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the ALU (A) and load (B) writeback paths.
// Each side has a small FIFO, a round-robin arbiter issues one registered write per cycle,
// and a pending-write scoreboard feeds two read-hazard flags to the stall logic.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  output logic              Regwrite,
  output logic [31:0]       pending,
  input  logic [ADDR_W-1:0] query_reg_1,
  input  logic [ADDR_W-1:0] query_reg_2,
  output logic              hazard_1,
  output logic              hazard_2
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  // Index 0 is requester A, index 1 is requester B.
  logic [ADDR_W-1:0] reg_q  [2][DEPTH];
  logic [DATA_W-1:0] data_q [2][DEPTH];
  logic [DEPTH-1:0]  vld_q  [2];
  logic [PtrW-1:0]   wptr_q [2];
  logic [PtrW-1:0]   rptr_q [2];
  logic [CntW-1:0]   cnt_q  [2];

  logic              rdy_q;
  logic              rr_q;
  logic              rr_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_reg_q;
  logic [DATA_W-1:0] wr_data_q;

  logic [ADDR_W-1:0] in_reg  [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        in_valid;
  logic [1:0]        has_head;
  logic [1:0]        full;
  logic [1:0]        ready;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic              issue;
  logic              grant;
  logic [31:0]       pend_c;

  assign in_valid   = {b_valid, a_valid};
  assign in_reg[0]  = a_reg;
  assign in_reg[1]  = b_reg;
  assign in_data[0] = a_data;
  assign in_data[1] = b_data;

  // FIFO status, handshake and round-robin grant; ready never looks at valid.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      has_head[s] = (cnt_q[s] != '0);
      full[s]     = (cnt_q[s] == CntW'(DEPTH));
      ready[s]    = rdy_q && !full[s];
      // Writes to r0 complete the handshake but are dropped.
      push[s]     = in_valid[s] && ready[s] && (in_reg[s] != '0);
    end
    issue = |has_head;
    if (&has_head) begin
      grant = rr_q;
    end else begin
      grant = has_head[1];
    end
    pop    = 2'b00;
    if (issue) begin
      pop[grant] = 1'b1;
    end
    rr_d = (&has_head) ? ~rr_q : rr_q;
  end

  assign a_ready = ready[0];
  assign b_ready = ready[1];

  // FIFO storage and pointers for both requesters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          reg_q[s][i]  <= '0;
          data_q[s][i] <= '0;
        end
        vld_q[s]  <= '0;
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        // Push never targets the popped slot: push needs !full, pop needs non-empty.
        if (pop[s]) begin
          vld_q[s][rptr_q[s]] <= 1'b0;
          rptr_q[s]           <= rptr_q[s] + 1'b1;
        end
        if (push[s]) begin
          reg_q[s][wptr_q[s]]  <= in_reg[s];
          data_q[s][wptr_q[s]] <= in_data[s];
          vld_q[s][wptr_q[s]]  <= 1'b1;
          wptr_q[s]            <= wptr_q[s] + 1'b1;
        end
        cnt_q[s] <= cnt_q[s] + CntW'(push[s]) - CntW'(pop[s]);
      end
    end
  end

  // Output stage, round-robin pointer and post-reset ready enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q     <= 1'b0;
      rr_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      rdy_q   <= 1'b1;
      rr_q    <= rr_d;
      wr_en_q <= issue;
      if (issue) begin
        wr_reg_q  <= reg_q[grant][rptr_q[grant]];
        wr_data_q <= data_q[grant][rptr_q[grant]];
      end
    end
  end

  assign Regwrite       = wr_en_q;
  assign write_register = wr_reg_q;
  assign write_data     = wr_data_q;

  // Pending scoreboard: every queued entry plus the write currently on the port.
  always_comb begin
    pend_c = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (vld_q[s][i]) begin
          pend_c[reg_q[s][i]] = 1'b1;
        end
      end
    end
    if (wr_en_q) begin
      pend_c[wr_reg_q] = 1'b1;
    end
    pend_c[0] = 1'b0;
  end

  assign pending  = pend_c;
  assign hazard_1 = pend_c[query_reg_1];
  assign hazard_2 = pend_c[query_reg_2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: per-side expected queues are filled on accepted
// handshakes and drained by an independent round-robin model when a write issues.
module tb_regfile_write_arbiter;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  typedef logic [ADDR_W+DATA_W-1:0] ent_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_valid, b_valid;
  logic [ADDR_W-1:0] a_reg, b_reg;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] write_data;
  logic              Regwrite;
  logic [31:0]       pending;
  logic [ADDR_W-1:0] query_reg_1, query_reg_2;
  logic              hazard_1, hazard_2;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_reg         (a_reg),
    .a_data        (a_data),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .b_reg         (b_reg),
    .b_data        (b_data),
    .write_register(write_register),
    .write_data    (write_data),
    .Regwrite      (Regwrite),
    .pending       (pending),
    .query_reg_1   (query_reg_1),
    .query_reg_2   (query_reg_2),
    .hazard_1      (hazard_1),
    .hazard_2      (hazard_2)
  );

  ent_t sa[$], sb[$];          // stimulus still to be offered
  ent_t ma[$], mb[$];          // expected queued writes per side
  logic              m_rdy, m_rr, m_out_v;
  ent_t              m_out;
  logic [ADDR_W-1:0] m_last_reg;
  logic [DATA_W-1:0] m_last_data;
  int                errors = 0;
  int                checks = 0;
  int                a_stalls = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] side_pend(input ent_t q[$]);
    logic [31:0] p;
    p = '0;
    foreach (q[i]) p[q[i][ADDR_W+DATA_W-1:DATA_W]] = 1'b1;
    return p;
  endfunction

  function automatic logic [31:0] model_pend();
    logic [31:0] p;
    p = side_pend(ma) | side_pend(mb);
    if (m_out_v) p[m_out[ADDR_W+DATA_W-1:DATA_W]] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // One clock: present stimulus heads at negedge, update model at posedge, check at negedge.
  task automatic step();
    logic        acc_a, acc_b, ha, hb, pick_b, exp_ra, exp_rb;
    logic [31:0] p;
    a_valid = (sa.size() != 0);
    b_valid = (sb.size() != 0);
    {a_reg, a_data} = a_valid ? sa[0] : '0;
    {b_reg, b_data} = b_valid ? sb[0] : '0;
    #1;
    exp_ra = m_rdy && (ma.size() < int'(DEPTH));
    exp_rb = m_rdy && (mb.size() < int'(DEPTH));
    check("a_ready", 64'(a_ready), 64'(exp_ra));
    check("b_ready", 64'(b_ready), 64'(exp_rb));
    if (a_valid && !a_ready && m_rdy) a_stalls++;
    acc_a = a_valid && exp_ra;
    acc_b = b_valid && exp_rb;
    if (acc_a && a_reg != '0) begin
      p = side_pend(mb);
      assert (!p[a_reg]) else $display("FAIL order_a: reg %0d pending on B", a_reg);
    end
    if (acc_b && b_reg != '0) begin
      p = side_pend(ma);
      assert (!p[b_reg]) else $display("FAIL order_b: reg %0d pending on A", b_reg);
    end
    @(posedge clk);
    ha      = (ma.size() != 0);
    hb      = (mb.size() != 0);
    pick_b  = (ha && hb) ? m_rr : hb;
    m_out_v = ha || hb;
    if (m_out_v) begin
      m_out       = pick_b ? mb.pop_front() : ma.pop_front();
      m_last_reg  = m_out[ADDR_W+DATA_W-1:DATA_W];
      m_last_data = m_out[DATA_W-1:0];
    end
    if (ha && hb) m_rr = ~m_rr;
    if (acc_a) begin
      void'(sa.pop_front());
      if (a_reg != '0) ma.push_back({a_reg, a_data});
    end
    if (acc_b) begin
      void'(sb.pop_front());
      if (b_reg != '0) mb.push_back({b_reg, b_data});
    end
    m_rdy = 1'b1;
    @(negedge clk);
    check("regwrite", 64'(Regwrite), 64'(m_out_v));
    check("wr_reg", 64'(write_register), 64'(m_last_reg));
    check("wr_data", 64'(write_data), 64'(m_last_data));
    p = model_pend();
    check("pending", 64'(pending), 64'(p));
    check("hazard_1", 64'(hazard_1), 64'(p[query_reg_1]));
    check("hazard_2", 64'(hazard_2), 64'(p[query_reg_2]));
  endtask

  task automatic model_clear();
    ma.delete();
    mb.delete();
    sa.delete();
    sb.delete();
    m_rdy       = 1'b0;
    m_rr        = 1'b0;
    m_out_v     = 1'b0;
    m_out       = '0;
    m_last_reg  = '0;
    m_last_data = '0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sa.size() + sb.size() + ma.size() + mb.size() != 0 || m_out_v) && n < 200) begin
      step();
      n++;
    end
    check(tag, 64'(sa.size() + sb.size() + ma.size() + mb.size()), 64'(0));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_regwrite"}, 64'(Regwrite), 64'(0));
    check({tag, "_wr_reg"}, 64'(write_register), 64'(0));
    check({tag, "_wr_data"}, 64'(write_data), 64'(0));
    check({tag, "_pending"}, 64'(pending), 64'(0));
    check({tag, "_ready"}, 64'({a_ready, b_ready}), 64'(0));
    check({tag, "_hazard"}, 64'({hazard_1, hazard_2}), 64'(0));
  endtask

  initial begin
    reset       = 1'b1;
    a_valid     = 1'b0;
    b_valid     = 1'b0;
    a_reg       = '0;
    b_reg       = '0;
    a_data      = '0;
    b_data      = '0;
    query_reg_1 = '0;
    query_reg_2 = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;
    step();  // ready rises at this edge

    // Single A write to r8: issue one edge after accept, pending clears after Regwrite.
    query_reg_1 = 5'd8;
    sa.push_back({5'd8, 32'h1234});
    repeat (4) step();

    // Both sides stream 8 writes with disjoint registers.
    query_reg_2 = 5'd17;
    for (int i = 0; i < 8; i++) begin
      sa.push_back({5'(i + 1), 32'hA000 + 32'(i)});
      sb.push_back({5'(i + 16), 32'hB000 + 32'(i)});
    end
    drain("stream_drain");

    // A bursts 5 back-to-back while B competes: A FIFO must fill and stall.
    a_stalls = 0;
    for (int i = 0; i < 5; i++) sa.push_back({5'(i + 10), 32'hC000 + 32'(i)});
    sb.push_back({5'd20, 32'hD000});
    sb.push_back({5'd21, 32'hD001});
    drain("burst_drain");
    check("a_backpressure", 64'(a_stalls != 0), 64'(1));

    // r0 write: handshake only.
    sa.push_back({5'd0, 32'hFFFF});
    repeat (3) step();
    check("r0_taken", 64'(sa.size()), 64'(0));

    // Hazard on r9 from a queued B load.
    query_reg_1 = 5'd9;
    query_reg_2 = 5'd3;
    sb.push_back({5'd9, 32'hAA});
    repeat (4) step();

    // Reset with writes in flight.
    for (int i = 0; i < 3; i++) sa.push_back({5'(i + 3), 32'hE000 + 32'(i)});
    sb.push_back({5'd25, 32'hF000});
    sb.push_back({5'd26, 32'hF001});
    repeat (2) step();
    a_valid = 1'b0;
    b_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_cleared("midreset");
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
